// File: rtl/seg_frame_decoder_if.sv
// Segment stream in, decoded frame results out, for seg_frame_decoder.
interface seg_frame_decoder_if;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic [3:0] num_a;
  logic [3:0] num_b;
  logic [3:0] num_r;
  logic [2:0] op_match;
  logic       frame_valid;
  logic       seg_err;
  logic       frame_abort;
  logic [7:0] frame_cnt;

  modport master (
    output seg_in, seg_valid,
    input  num_a, num_b, num_r, op_match, frame_valid, seg_err, frame_abort, frame_cnt
  );
  modport slave (
    input  seg_in, seg_valid,
    output num_a, num_b, num_r, op_match, frame_valid, seg_err, frame_abort, frame_cnt
  );
endinterface

// File: rtl/seg_frame_decoder.sv
// Decodes a 7-segment digit stream into A/B/R frames and flags which of
// add/sub/mul each frame satisfies.
module seg_frame_decoder #(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  seg_frame_decoder_if.slave bus
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_R, EVAL} state_t;

  state_t     state_q;
  logic [7:0] gap_q;
  logic [3:0] a_q, b_q, r_q;
  logic [3:0] num_a_q, num_b_q, num_r_q;
  logic [2:0] op_match_q;
  logic       frame_valid_q, seg_err_q, frame_abort_q;
  logic [7:0] frame_cnt_q;

  logic       dig_ok;
  logic [3:0] dig;
  logic [2:0] op_match_d;
  logic       gap_hit;

  // Exact-match decode; anything off-table (blank included) is rejected.
  always_comb begin
    dig_ok = 1'b1;
    dig    = 4'd0;
    case (bus.seg_in)
      7'b1111110: dig = 4'd0;
      7'b0110000: dig = 4'd1;
      7'b1101101: dig = 4'd2;
      7'b1111001: dig = 4'd3;
      7'b1110011: dig = 4'd4;
      7'b1011011: dig = 4'd5;
      7'b1011111: dig = 4'd6;
      7'b1110000: dig = 4'd7;
      7'b1111111: dig = 4'd8;
      7'b1111011: dig = 4'd9;
      default:    dig_ok = 1'b0;
    endcase
  end

  // Subtraction only matches without borrow, so A<B never hits.
  always_comb begin
    op_match_d    = 3'b000;
    op_match_d[0] = ({1'b0, a_q} + {1'b0, b_q}) == {1'b0, r_q};
    op_match_d[1] = (a_q >= b_q) && ((a_q - b_q) == r_q);
    op_match_d[2] = ({3'b000, a_q} * {3'b000, b_q}) == {3'b000, r_q};
  end

  assign gap_hit = (gap_q == 8'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_A;
      gap_q         <= 8'd0;
      a_q           <= 4'd0;
      b_q           <= 4'd0;
      r_q           <= 4'd0;
      num_a_q       <= 4'd0;
      num_b_q       <= 4'd0;
      num_r_q       <= 4'd0;
      op_match_q    <= 3'b000;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      case (state_q)
        WAIT_A, EVAL: begin
          if (state_q == EVAL) begin
            num_a_q       <= a_q;
            num_b_q       <= b_q;
            num_r_q       <= r_q;
            op_match_q    <= op_match_d;
            frame_valid_q <= 1'b1;
            frame_cnt_q   <= frame_cnt_q + 8'd1;
          end
          gap_q   <= 8'd0;
          state_q <= WAIT_A;
          // A strobe during EVAL is the next frame's operand A.
          if (bus.seg_valid) begin
            if (dig_ok) begin
              a_q     <= dig;
              state_q <= WAIT_B;
            end else begin
              seg_err_q <= 1'b1;
            end
          end
        end
        WAIT_B, WAIT_R: begin
          if (bus.seg_valid) begin
            gap_q <= 8'd0;
            if (!dig_ok) begin
              seg_err_q <= 1'b1;
              state_q   <= WAIT_A;
            end else if (state_q == WAIT_B) begin
              b_q     <= dig;
              state_q <= WAIT_R;
            end else begin
              r_q     <= dig;
              state_q <= EVAL;
            end
          end else if (gap_hit) begin
            gap_q         <= 8'd0;
            frame_abort_q <= 1'b1;
            state_q       <= WAIT_A;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign bus.num_a       = num_a_q;
  assign bus.num_b       = num_b_q;
  assign bus.num_r       = num_r_q;
  assign bus.op_match    = op_match_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: doc/seg_frame_decoder.md
# seg_frame_decoder

Receive side of the game's 7-segment digit stream. Accepts segment patterns (abcdefg, as driven on `num_led`) one per strobe and decodes them back to BCD digits. Assembles each three-digit frame (operand A, operand B, result) and reports which of add/sub/mul the frame satisfies. Used as an answer checker and as the bench-side monitor for the display path.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle cycles allowed between digits of one frame before the frame is aborted; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous reset `reset`, active-high.
- `seg_in`  in  7  segment pattern, bit6=a … bit0=g, active-high.
- `seg_valid`  in  1  `seg_in` is sampled on every edge where this is high.
- `num_a`  out  4  decoded operand A of last good frame.
- `num_b`  out  4  decoded operand B.
- `num_r`  out  4  decoded result digit.
- `op_match`  out  3  bit0 A+B==R, bit1 A−B==R, bit2 A×B==R.
- `frame_valid`  out  1  one-cycle pulse; `num_*` and `op_match` are updated.
- `seg_err`  out  1  one-cycle pulse; unrecognised pattern received.
- `frame_abort`  out  1  one-cycle pulse; inter-digit gap timeout.
- `frame_cnt`  out  8  count of good frames, wraps 255→0.

## Operation
- Decode table, exact match only: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=1110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Any other pattern, including 0000000, is invalid.
- States:
  - WAIT_A: a valid digit stores A and moves to WAIT_B.
  - WAIT_B: a valid digit stores B and moves to WAIT_R.
  - WAIT_R: a valid digit stores R and moves to EVAL.
  - EVAL: lasts one cycle, then returns to WAIT_A.
- In EVAL:
  - Compute `op_match`.
  - Copy the internal A/B/R into `num_a`/`num_b`/`num_r`.
  - Pulse `frame_valid`.
  - Increment `frame_cnt`.
- Arithmetic:
  - Sum is 5 bits.
  - Difference: bit1 is set only when A≥B and A−B==R; no wrap.
  - Product is 7 bits, max 81.
  - All comparisons are against zero-extended R.
- An invalid pattern in any wait state:
  - pulse `seg_err`;
  - discard the partial frame and go to WAIT_A;
  - leave `num_*`, `op_match` and `frame_cnt` unchanged.
- Gap counter:
  - Cleared on every accepted strobe; counts cycles in WAIT_B and WAIT_R with `seg_valid` low.
  - On reaching `GAP_CYCLES`, pulse `frame_abort` and go to WAIT_A.
  - Not active in WAIT_A.
- `seg_valid` high during EVAL: the pattern is processed as digit A of the next frame. Valid → go to WAIT_B. Invalid → pulse `seg_err` and go to WAIT_A.
- Timeout and strobe on the same edge: the strobe wins and no abort is raised.
- Outputs hold their last good frame until the next good frame.

## Timing
- Reset (synchronous, any state, including mid-frame):
  - next state WAIT_A, gap counter 0;
  - `num_a`=`num_b`=`num_r`=0, `op_match`=000, `frame_cnt`=0;
  - `frame_valid`=`seg_err`=`frame_abort`=0.
  - Reset overrides a simultaneous `seg_valid`.
- Latency: the edge sampling R enters EVAL. On the next edge, `frame_valid` and updated outputs are registered. They are visible for exactly one cycle, starting on the 2nd edge after R is sampled.
- `seg_err` is registered: high for the cycle after the edge that sampled the bad pattern.
- `frame_abort` is registered: high for the cycle after the edge on which the counter reaches `GAP_CYCLES`.
- Throughput: back-to-back strobes every cycle are legal. One frame per 3 strobes; EVAL overlaps the next A.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset, then strobes 1011011, 1111001, 1111111 (5,3,8) on consecutive cycles → `num_a`=5, `num_b`=3, `num_r`=8, `op_match`=001, `frame_valid` pulse 2 edges after the 3rd strobe, `frame_cnt`=1.
- Frames 4,2,2 then 2,2,4, strobes back-to-back → `op_match`=010, then 101; `frame_cnt`=2; no dropped digits.
- Digit 7, then pattern 0110011 → `seg_err` pulse. Then 2,1,3 → `op_match`=001, `frame_cnt` increments by 1 only.
- `GAP_CYCLES`=4: digit 6, then idle 4 cycles → `frame_abort` pulse, outputs unchanged. Digit arriving on the 4th idle edge → no abort, frame continues.
- Reset asserted after A and B are received → all outputs 0. Next three digits 3,3,9 → one good frame, `op_match`=100.
- 256 good frames → `frame_cnt` wraps to 0 and the `frame_valid` count equals 256.
